// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared definitions for the key pulse conditioner.
//   key_state_e : per-key debounce FSM state encoding
//   cnt_width() : bits needed to hold a counter whose largest value is max_count
package key_cond_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  // A counter never narrower than one bit, wide enough that max_count never wraps.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// key_debounce_fsm: debounce, press-pulse and auto-repeat for one synchronised key.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   tick_i  : sample-tick strobe; the FSM only advances when it is high
//   sync_i  : synchronised raw key level
//   pulse_o : one-clock pulse per accepted press or repeat
//   level_o : debounced key level
//   state_o : current FSM state (debug)
module key_debounce_fsm
  import key_cond_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_PERIOD  = 25
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       sync_i,
  output logic       pulse_o,
  output logic       level_o,
  output logic [1:0] state_o
);

  // cnt holds 1..DEBOUNCE_TICKS-1; reaching the last value on a stable tick
  // is the same as cnt+1 == DEBOUNCE_TICKS.
  localparam int CW = cnt_width(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  // rep counts 0..REPEAT_DELAY-1 before the first repeat, then cycles
  // REPEAT_DELAY..REPEAT_DELAY+REPEAT_PERIOD-1, reloading on every repeat pulse
  // so it can never wrap.
  localparam int RW = cnt_width(REPEAT_DELAY + REPEAT_PERIOD - 1);
  localparam bit            REP_EN    = (REPEAT_DELAY > 0);
  localparam logic [RW-1:0] REP_ONE   = RW'(1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_BASE  = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          press_hit, rep_hit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    level_d   = level_q;
    press_hit = 1'b0;
    rep_hit   = 1'b0;
    if (tick_i) begin
      case (state_q)
        IDLE: begin
          if (sync_i) begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!sync_i) begin
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = HELD;
            level_d   = 1'b1;
            press_hit = 1'b1;
            rep_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync_i) begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_ONE;
          end else if (REP_EN) begin
            if (rep_q == REP_FIRST || rep_q == REP_LAST) begin
              rep_d   = REP_BASE;
              rep_hit = 1'b1;
            end else begin
              rep_d = rep_q + REP_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          // A glitch back to high returns to HELD with rep untouched.
          if (sync_i) begin
            state_d = HELD;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Suppress a pulse directly after another so the output is never high
    // two clocks running (only reachable with very short repeat settings).
    pulse_d = (press_hit | rep_hit) & ~pulse_q;
  end

  assign pulse_o = pulse_q;
  assign level_o = level_q;
  assign state_o = state_q;

endmodule

// File: rtl/key_pulse_conditioner.sv
// key_pulse_conditioner: synchronises, debounces and pulse-shapes raw keys.
// Ports:
//   clk100mhz : system clock
//   clr       : asynchronous active-low reset
//   key_raw   : raw, bouncy, asynchronous key levels (bit 0 = add, bit 1 = left)
//   key_pulse : one-clock pulse per accepted press or auto-repeat
//   key_level : debounced key levels
//   tick      : sample-tick strobe
//   dbg_state : per-key FSM state, two bits per key (debug)
module key_pulse_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS         = 2,
  parameter int TICK_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int REPEAT_DELAY   = 0,
  parameter int REPEAT_PERIOD  = 25
) (
  input  logic                  clk100mhz,
  input  logic                  clr,
  input  logic [N_KEYS-1:0]     key_raw,
  output logic [N_KEYS-1:0]     key_pulse,
  output logic [N_KEYS-1:0]     key_level,
  output logic                  tick,
  output logic [2*N_KEYS-1:0]   dbg_state
);

  localparam int DW = cnt_width(TICK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [N_KEYS-1:0] meta_q, sync_q;
  logic [DW-1:0]     div_q, div_d;
  logic              tick_q, tick_d;

  assign div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
  assign tick_d = (div_q == DIV_LAST);

  always_ff @(posedge clk100mhz or negedge clr) begin
    if (!clr) begin
      meta_q <= '0;
      sync_q <= '0;
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      meta_q <= key_raw;
      sync_q <= meta_q;
      div_q  <= div_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_key (
      .clk_i   (clk100mhz),
      .rst_ni  (clr),
      .tick_i  (tick_q),
      .sync_i  (sync_q[k]),
      .pulse_o (key_pulse[k]),
      .level_o (key_level[k]),
      .state_o (dbg_state[2*k +: 2])
    );
  end

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Bench for key_pulse_conditioner. Three instances:
//   dut0 : TICK_DIV=1, DEBOUNCE_TICKS=4, no repeat
//   dut1 : TICK_DIV=1, DEBOUNCE_TICKS=4, REPEAT_DELAY=8, REPEAT_PERIOD=3
//   dut2 : TICK_DIV=4, DEBOUNCE_TICKS=4, no repeat
// cyc counts rising edges since clr was released; expected pulses are queued
// as {edge number, pulse bits} and checked on the falling edge after that edge.
module tb_key_pulse_conditioner;

  localparam int DEB = 4;
  localparam int W   = 34;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] raw0, raw1, raw2;
  logic [1:0] pulse0, pulse1, pulse2;
  logic [1:0] level0, level1, level2;
  logic       tick0, tick1, tick2;
  logic [3:0] dbg0, dbg1, dbg2;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_rep_q[$];
  logic [W-1:0] exp_div_q[$];
  logic [W-1:0] head0, head1, head2;

  key_pulse_conditioner #(.N_KEYS(2), .TICK_DIV(1), .DEBOUNCE_TICKS(DEB),
                          .REPEAT_DELAY(0), .REPEAT_PERIOD(25)) dut0 (
    .clk100mhz(clk), .clr(clr), .key_raw(raw0), .key_pulse(pulse0),
    .key_level(level0), .tick(tick0), .dbg_state(dbg0));

  key_pulse_conditioner #(.N_KEYS(2), .TICK_DIV(1), .DEBOUNCE_TICKS(DEB),
                          .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) dut1 (
    .clk100mhz(clk), .clr(clr), .key_raw(raw1), .key_pulse(pulse1),
    .key_level(level1), .tick(tick1), .dbg_state(dbg1));

  key_pulse_conditioner #(.N_KEYS(2), .TICK_DIV(4), .DEBOUNCE_TICKS(DEB),
                          .REPEAT_DELAY(0), .REPEAT_PERIOD(25)) dut2 (
    .clk100mhz(clk), .clr(clr), .key_raw(raw2), .key_pulse(pulse2),
    .key_level(level2), .tick(tick2), .dbg_state(dbg2));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or negedge clr) begin
    if (!clr) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // ---------------- model helpers ----------------
  function automatic logic [W-1:0] stamp(input int c, input logic [1:0] b);
    return {32'(c), b};
  endfunction

  // Raw first sampled at edge n: the FSM first sees it at the earliest tick
  // edge e >= n+2 (ticks sit after edges that are multiples of td), then needs
  // DEB-1 further ticks.
  function automatic int exp_edge(input int n, input int td);
    int e = n + 2;
    while (((e - 1) % td) != 0) e++;
    return e + (DEB - 1) * td;
  endfunction

  // ---------------- scoreboards ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0 && int'(exp_q[0][W-1:2]) < cyc) begin
      head0 = exp_q.pop_front(); n_checks++; n_errors++;
      $display("FAIL main_pulse_missing: none at edge %0d (now %0d), required %b", int'(head0[W-1:2]), cyc, head0[1:0]);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][W-1:2]) == cyc) begin
      head0 = exp_q.pop_front(); n_checks++;
      if (pulse0 !== head0[1:0]) begin
        n_errors++;
        $display("FAIL main_pulse: edge %0d got %b, required %b", cyc, pulse0, head0[1:0]);
      end
    end else if (pulse0 !== 2'b00) begin
      n_checks++; n_errors++;
      $display("FAIL main_pulse_unexpected: edge %0d got %b, required 00", cyc, pulse0);
    end
  end

  always @(negedge clk) begin
    if (exp_rep_q.size() > 0 && int'(exp_rep_q[0][W-1:2]) < cyc) begin
      head1 = exp_rep_q.pop_front(); n_checks++; n_errors++;
      $display("FAIL rep_pulse_missing: none at edge %0d (now %0d), required %b", int'(head1[W-1:2]), cyc, head1[1:0]);
    end
    if (exp_rep_q.size() > 0 && int'(exp_rep_q[0][W-1:2]) == cyc) begin
      head1 = exp_rep_q.pop_front(); n_checks++;
      if (pulse1 !== head1[1:0]) begin
        n_errors++;
        $display("FAIL rep_pulse: edge %0d got %b, required %b", cyc, pulse1, head1[1:0]);
      end
    end else if (pulse1 !== 2'b00) begin
      n_checks++; n_errors++;
      $display("FAIL rep_pulse_unexpected: edge %0d got %b, required 00", cyc, pulse1);
    end
  end

  always @(negedge clk) begin
    if (exp_div_q.size() > 0 && int'(exp_div_q[0][W-1:2]) < cyc) begin
      head2 = exp_div_q.pop_front(); n_checks++; n_errors++;
      $display("FAIL div_pulse_missing: none at edge %0d (now %0d), required %b", int'(head2[W-1:2]), cyc, head2[1:0]);
    end
    if (exp_div_q.size() > 0 && int'(exp_div_q[0][W-1:2]) == cyc) begin
      head2 = exp_div_q.pop_front(); n_checks++;
      if (pulse2 !== head2[1:0]) begin
        n_errors++;
        $display("FAIL div_pulse: edge %0d got %b, required %b", cyc, pulse2, head2[1:0]);
      end
    end else if (pulse2 !== 2'b00) begin
      n_checks++; n_errors++;
      $display("FAIL div_pulse_unexpected: edge %0d got %b, required 00", cyc, pulse2);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != t) begin
      n_checks++; n_errors++;
      $display("FAIL wait_cyc: at edge %0d, required %0d", cyc, t);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() + exp_rep_q.size() + exp_div_q.size()) != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ((exp_q.size() + exp_rep_q.size() + exp_div_q.size()) != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected pulses never seen, required 0",
               exp_q.size() + exp_rep_q.size() + exp_div_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({pulse0, level0, tick0, dbg0} !== 9'd0) begin
      n_errors++; $display("FAIL reset_dut0: got %h, required 0", {pulse0, level0, tick0, dbg0});
    end
    n_checks++;
    if ({pulse1, level1, tick1, dbg1} !== 9'd0) begin
      n_errors++; $display("FAIL reset_dut1: got %h, required 0", {pulse1, level1, tick1, dbg1});
    end
    n_checks++;
    if ({pulse2, level2, tick2, dbg2} !== 9'd0) begin
      n_errors++; $display("FAIL reset_dut2: got %h, required 0", {pulse2, level2, tick2, dbg2});
    end
    clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tick0 !== 1'b1) begin
      n_errors++; $display("FAIL tick_div1_first: got %b, required 1", tick0);
    end
  endtask

  task automatic test_clean_press();
    int n, e, m;
    @(negedge clk);
    raw0[0] = 1'b1;
    n = cyc + 1;
    e = exp_edge(n, 1);
    exp_q.push_back(stamp(e, 2'b01));
    wait_cyc(n + 2);
    n_checks++;
    if (dbg0[1:0] !== 2'd1) begin
      n_errors++; $display("FAIL clean_state_pw: got %0d, required 1", dbg0[1:0]);
    end
    wait_cyc(e - 1);
    n_checks++;
    if (level0 !== 2'b00) begin
      n_errors++; $display("FAIL clean_level_early: got %b, required 00", level0);
    end
    wait_cyc(e);
    n_checks++;
    if (level0 !== 2'b01 || dbg0[1:0] !== 2'd2) begin
      n_errors++; $display("FAIL clean_level_held: got level %b state %0d, required 01 state 2", level0, dbg0[1:0]);
    end
    wait_cyc(n + 9);
    raw0[0] = 1'b0;
    m = cyc + 1;
    wait_cyc(m + 4);
    n_checks++;
    if (level0 !== 2'b01) begin
      n_errors++; $display("FAIL clean_release_early: got %b, required 01", level0);
    end
    wait_cyc(m + 5);
    n_checks++;
    if (level0 !== 2'b00) begin
      n_errors++; $display("FAIL clean_release: got %b, required 00", level0);
    end
    drain();
  endtask

  task automatic test_bounce();
    logic [5:0] pat = 6'b011011;
    for (int i = 0; i < 6; i++) begin
      raw0[0] = pat[i];
      @(negedge clk);
    end
    raw0[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (level0 !== 2'b00) begin
        n_errors++; $display("FAIL bounce_level: edge %0d got %b, required 00", cyc, level0);
      end
    end
  endtask

  task automatic test_release_glitch();
    int n, e, m;
    @(negedge clk);
    raw0[0] = 1'b1;
    n = cyc + 1;
    e = exp_edge(n, 1);
    exp_q.push_back(stamp(e, 2'b01));
    wait_cyc(e + 1);
    raw0[0] = 1'b0;
    repeat (2) @(negedge clk);
    raw0[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (level0 !== 2'b01) begin
        n_errors++; $display("FAIL glitch_level: edge %0d got %b, required 01", cyc, level0);
      end
    end
    raw0[0] = 1'b0;
    m = cyc + 1;
    wait_cyc(m + 4);
    n_checks++;
    if (level0 !== 2'b01) begin
      n_errors++; $display("FAIL glitch_release_early: got %b, required 01", level0);
    end
    wait_cyc(m + 5);
    n_checks++;
    if (level0 !== 2'b00) begin
      n_errors++; $display("FAIL glitch_release: got %b, required 00", level0);
    end
    drain();
  endtask

  task automatic test_repeat();
    int n, e, m;
    @(negedge clk);
    raw1[1] = 1'b1;
    n = cyc + 1;
    e = exp_edge(n, 1);
    m = n + 25;
    exp_rep_q.push_back(stamp(e, 2'b10));
    // HELD still sees the key high up to edge m+1.
    for (int p = e + 8; p <= m + 1; p += 3) exp_rep_q.push_back(stamp(p, 2'b10));
    wait_cyc(e);
    n_checks++;
    if (level1 !== 2'b10) begin
      n_errors++; $display("FAIL repeat_level: got %b, required 10", level1);
    end
    wait_cyc(m - 1);
    raw1[1] = 1'b0;
    wait_cyc(m + 5);
    n_checks++;
    if (level1 !== 2'b00) begin
      n_errors++; $display("FAIL repeat_release: got %b, required 00", level1);
    end
    drain();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_tick_div();
    int n, e, m, f;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (tick2 !== ((cyc % 4) == 0)) begin
        n_errors++; $display("FAIL tick_div4: edge %0d got %b, required %b", cyc, tick2, (cyc % 4) == 0);
      end
    end
    raw2[0] = 1'b1;
    n = cyc + 1;
    e = exp_edge(n, 4);
    exp_div_q.push_back(stamp(e, 2'b01));
    wait_cyc(e - 1);
    n_checks++;
    if (level2 !== 2'b00) begin
      n_errors++; $display("FAIL div_level_early: got %b, required 00", level2);
    end
    wait_cyc(e);
    n_checks++;
    if (level2 !== 2'b01) begin
      n_errors++; $display("FAIL div_level: got %b, required 01", level2);
    end
    wait_cyc(e + 3);
    raw2[0] = 1'b0;
    m = cyc + 1;
    f = exp_edge(m, 4);
    wait_cyc(f - 1);
    n_checks++;
    if (level2 !== 2'b01) begin
      n_errors++; $display("FAIL div_release_early: got %b, required 01", level2);
    end
    wait_cyc(f);
    n_checks++;
    if (level2 !== 2'b00) begin
      n_errors++; $display("FAIL div_release: got %b, required 00", level2);
    end
    drain();
  endtask

  task automatic test_simultaneous_reset();
    int n, e, m;
    @(negedge clk);
    raw0 = 2'b11;
    n = cyc + 1;
    e = exp_edge(n, 1);
    exp_q.push_back(stamp(e, 2'b11));
    wait_cyc(e);
    n_checks++;
    if (level0 !== 2'b11) begin
      n_errors++; $display("FAIL simul_level: got %b, required 11", level0);
    end
    raw0 = 2'b00;
    m = cyc + 1;
    wait_cyc(m + 5);
    drain();
    // Second press, interrupted by reset while both keys are in PRESS_WAIT.
    raw0 = 2'b11;
    n = cyc + 1;
    wait_cyc(n + 3);
    n_checks++;
    if (dbg0 !== 4'b0101) begin
      n_errors++; $display("FAIL simul_state_pw: got %b, required 0101", dbg0);
    end
    #2 clr = 1'b0;
    #1;
    n_checks++;
    if ({pulse0, level0, tick0, dbg0, tick1, tick2} !== 11'd0) begin
      n_errors++; $display("FAIL reset_async: got %h, required 0", {pulse0, level0, tick0, dbg0, tick1, tick2});
    end
    @(negedge clk);
    n_checks++;
    if ({pulse0, level0, dbg0} !== 8'd0) begin
      n_errors++; $display("FAIL reset_hold: got %h, required 0", {pulse0, level0, dbg0});
    end
    // Key still high on release: a fresh press sampled first at edge 1.
    e = exp_edge(1, 1);
    exp_q.push_back(stamp(e, 2'b11));
    clr = 1'b1;
    wait_cyc(e - 1);
    n_checks++;
    if (level0 !== 2'b00) begin
      n_errors++; $display("FAIL post_reset_early: got %b, required 00", level0);
    end
    wait_cyc(e);
    n_checks++;
    if (level0 !== 2'b11) begin
      n_errors++; $display("FAIL post_reset_level: got %b, required 11", level0);
    end
    raw0 = 2'b00;
    m = cyc + 1;
    wait_cyc(m + 5);
    n_checks++;
    if (level0 !== 2'b00) begin
      n_errors++; $display("FAIL post_reset_release: got %b, required 00", level0);
    end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    raw0 = 2'b00;
    raw1 = 2'b00;
    raw2 = 2'b00;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_repeat();
    test_tick_div();
    test_simultaneous_reset();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/key_pulse_conditioner.md
Name: key_pulse_conditioner

Overview:
- Front-end conditioner for the raw slide-switch/button inputs (add, shift-left) that drive the flowing-light/seven-segment top.
- Each raw key is synchronised, debounced on a prescaled sample tick, and turned into a clean one-clock pulse per press.
- An optional auto-repeat emits further pulses while a key is held.
- The outputs connect directly to the top's sw_add / sw_left inputs.

Parameters:
- N_KEYS, 2, number of independent keys (bit 0 = add, bit 1 = left).
- TICK_DIV, 100000, clk100mhz cycles per sample tick (1 = every cycle); must be >= 1.
- DEBOUNCE_TICKS, 20, consecutive stable ticks needed to accept a press or release; must be >= 2.
- REPEAT_DELAY, 0, held ticks before the first auto-repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 25, ticks between subsequent repeat pulses; must be >= 1.

Ports:
- clk100mhz  input  1  system clock
- clr  input  1  asynchronous active-low reset
- key_raw  input  N_KEYS  raw, bouncy, asynchronous key levels
- key_pulse  output  N_KEYS  one-clock pulse per accepted press or repeat
- key_level  output  N_KEYS  debounced key level
- tick  output  1  sample-tick strobe, exported for bench observability

Behaviour:
- Reset (clr=0, async):
  - synchronisers, prescaler, all counters, key_pulse, key_level and tick clear to 0.
  - All FSMs go to IDLE.
- Synchroniser: 2-flop per key; sync = second flop.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is registered high for exactly one clock when the count equals TICK_DIV-1.
- Per-key FSM advances only on tick cycles; it holds otherwise.
- Per-key FSM states:
  - IDLE: sync=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT:
    - sync=0 -> IDLE (bounce rejected; no pulse).
    - Otherwise cnt+1; when cnt+1 == DEBOUNCE_TICKS -> HELD, key_level<=1, key_pulse<=1, rep=0.
  - HELD:
    - sync=0 -> RELEASE_WAIT, cnt=1.
    - Otherwise, if REPEAT_DELAY>0, rep+1.
    - Pulse when rep+1 == REPEAT_DELAY, then every REPEAT_PERIOD ticks after that. rep saturates/reloads so it never wraps into a spurious pulse.
  - RELEASE_WAIT:
    - sync=1 -> HELD (glitch rejected; rep keeps its value; no pulse).
    - Otherwise cnt+1; when cnt+1 == DEBOUNCE_TICKS -> IDLE, key_level<=0.
  - No pulse is ever generated on release.
- key_pulse:
  - Registered; high exactly one clock, the cycle after the accepting tick edge.
  - Never high two consecutive clocks.
- Latency, TICK_DIV=1: raw first sampled high at edge N (held stable) -> key_pulse and key_level rise at edge N+1+DEBOUNCE_TICKS.
- Counter widths are $clog2 of the largest count plus 1. No arithmetic overflow is permitted.
- Keys are fully independent. Simultaneous presses give pulses in the same cycle.
- Reset mid-debounce discards all progress. If a key is still high when clr releases, it is treated as a fresh press and yields a full-latency pulse.
- A change of key_raw between ticks is invisible except via its sampled value at the tick.

Decomposition:
- Package key_cond_pkg holds:
  - the FSM state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, HELD=2'd2, RELEASE_WAIT=2'd3);
  - a width helper function.
- Sub-module key_debounce_fsm (one key: FSM, cnt, rep, pulse/level registers) is instantiated N_KEYS times by generate.
- Synchroniser and prescaler stay in the parent.

Test Plan:
(all cases use TICK_DIV=1, DEBOUNCE_TICKS=4, REPEAT_DELAY=0 unless stated)
- Clean press: key_raw[0] 0->1 sampled at edge 10, held 10 cycles -> key_pulse[0] high only in the cycle after edge 15; key_level[0] 1 from edge 15; key_pulse[1] stays 0.
- Bounce rejection: key_raw[0] pattern 1,1,0,1,1,0 (one cycle each) -> key_pulse and key_level stay 0 throughout.
- Release glitch while HELD: raw low for 2 cycles, then high -> key_level stays 1, no new pulse. Raw low for >=5 cycles -> key_level falls 5 edges after the first low sample, no pulse.
- Auto-repeat (REPEAT_DELAY=8, REPEAT_PERIOD=3): hold key 1 -> pulses at HELD entry E, then E+8, E+11, E+14, and so on. No pulse after the release is detected.
- Simultaneous press of keys 0 and 1 at the same edge -> both pulses in the same cycle. Then assert clr during PRESS_WAIT of a second press: all outputs go 0 immediately. Release clr with raw still high -> pulse 1+4 edges after the first sync sample.
- TICK_DIV=4: clean press -> tick period of 4 clocks; key_pulse latency equals 2 sync clocks plus 4 ticks (about 16 clocks), pulse still one clock wide.
